// File: rtl/period_meter.sv
// Period meter: synchronises an asynchronous input, then counts clk cycles between
// its rising edges. Reports each accepted period, glitches and edge-loss timeouts.
module period_meter #(
    parameter int unsigned WIDTH      = 16,
    parameter int unsigned MIN_PERIOD = 4,
    parameter int unsigned MAX_COUNT  = 16'hffff
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             sig_in,
    output logic [WIDTH-1:0] period,
    output logic             valid,
    output logic             timeout,
    output logic             locked,
    output logic             glitch
);

    localparam logic [WIDTH-1:0] CNT_LAST = WIDTH'(MAX_COUNT - 1);
    localparam logic [WIDTH-1:0] MIN_PER  = WIDTH'(MIN_PERIOD);

    typedef enum logic {
        IDLE,
        MEASURE
    } state_t;

    state_t           state_q, state_d;
    logic             s1_q, s1_d;
    logic             s2_q, s2_d;
    logic             s3_q, s3_d;
    logic [WIDTH-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] period_q, period_d;
    logic             valid_q, valid_d;
    logic             timeout_q, timeout_d;
    logic             glitch_q, glitch_d;
    logic             locked_q, locked_d;
    logic             sig_edge;
    logic [WIDTH-1:0] cnt_inc;

    assign sig_edge = s2_q & ~s3_q;
    // cnt stops at MAX_COUNT-1, so this increment cannot overflow WIDTH.
    assign cnt_inc  = cnt_q + WIDTH'(1);

    always_comb begin
        state_d   = state_q;
        s1_d      = sig_in;
        s2_d      = s1_q;
        s3_d      = s2_q;
        cnt_d     = cnt_q;
        period_d  = period_q;
        valid_d   = 1'b0;
        timeout_d = 1'b0;
        glitch_d  = 1'b0;

        case (state_q)
            IDLE: begin
                if (sig_edge) begin
                    state_d = MEASURE;
                    cnt_d   = '0;
                end
            end
            MEASURE: begin
                if (sig_edge) begin
                    if (cnt_inc >= MIN_PER) begin
                        period_d = cnt_inc;
                        valid_d  = 1'b1;
                        cnt_d    = '0;
                    end else begin
                        // Rejected edge: keep timing from the last accepted edge.
                        glitch_d = 1'b1;
                        cnt_d    = cnt_inc;
                    end
                end else if (cnt_q == CNT_LAST) begin
                    timeout_d = 1'b1;
                    cnt_d     = '0;
                    state_d   = IDLE;
                end else begin
                    cnt_d = cnt_inc;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase

        locked_d = (state_d == MEASURE);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            s1_q      <= 1'b0;
            s2_q      <= 1'b0;
            s3_q      <= 1'b0;
            cnt_q     <= '0;
            period_q  <= '0;
            valid_q   <= 1'b0;
            timeout_q <= 1'b0;
            glitch_q  <= 1'b0;
            locked_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            s1_q      <= s1_d;
            s2_q      <= s2_d;
            s3_q      <= s3_d;
            cnt_q     <= cnt_d;
            period_q  <= period_d;
            valid_q   <= valid_d;
            timeout_q <= timeout_d;
            glitch_q  <= glitch_d;
            locked_q  <= locked_d;
        end
    end

    assign period  = period_q;
    assign valid   = valid_q;
    assign timeout = timeout_q;
    assign glitch  = glitch_q;
    assign locked  = locked_q;

endmodule

// File: tb/tb_period_meter.sv
// Scoreboarded bench for period_meter: a rising-edge timing model predicts
// valid/glitch/timeout events, a negedge monitor pops and compares them.
module tb_period_meter;

    localparam int unsigned WIDTH = 16;
    localparam int unsigned MINP  = 4;
    localparam int unsigned MAXC  = 200;
    localparam int          LAT   = 2;

    logic             clk = 1'b0;
    logic             reset = 1'b1;
    logic             sig_in = 1'b0;
    logic [WIDTH-1:0] period;
    logic             valid, timeout, locked, glitch;

    period_meter #(.WIDTH(WIDTH), .MIN_PERIOD(MINP), .MAX_COUNT(MAXC)) dut (
        .clk(clk), .reset(reset), .sig_in(sig_in), .period(period),
        .valid(valid), .timeout(timeout), .locked(locked), .glitch(glitch)
    );

    always #5 clk = ~clk;

    typedef struct {
        int kind;   // 0 valid, 1 timeout, 2 glitch
        int per;
        int cyc;
    } ev_t;

    ev_t sbq[$];
    int  npass = 0;
    int  ntotal = 0;
    int  cyc = 0;
    bit  rst_seen = 1'b0;
    int  per_h[3];
    bit  lk_h[3];

    task automatic chk(input string name, input longint act, input longint exp);
        ntotal++;
        if (act == exp) npass++;
        else $display("FAIL %s at cycle %0d: got %0d expected %0d", name, cyc, act, exp);
    endtask

    // Reference model: works on sampled rising edges and their spacing in cycles.
    initial begin
        bit prev, locked_m, s, rise;
        int last, per_m, d;
        prev = 0; locked_m = 0; last = 0; per_m = 0;
        for (int i = 0; i < 3; i++) begin per_h[i] = 0; lk_h[i] = 0; end
        forever begin
            @(posedge clk);
            cyc++;
            s = sig_in;
            if (reset) begin
                rst_seen = 1;
                prev = 0; locked_m = 0; per_m = 0;
                sbq.delete();
                for (int i = 0; i < 3; i++) begin per_h[i] = 0; lk_h[i] = 0; end
            end else begin
                rst_seen = 0;
                rise = s & ~prev;
                prev = s;
                d = cyc - last;
                if (rise) begin
                    if (!locked_m) begin
                        locked_m = 1;
                        last = cyc;
                    end else if (d >= int'(MINP)) begin
                        per_m = d;
                        last = cyc;
                        sbq.push_back('{kind: 0, per: d, cyc: cyc + LAT});
                    end else begin
                        sbq.push_back('{kind: 2, per: per_m, cyc: cyc + LAT});
                    end
                end else if (locked_m && d == int'(MAXC)) begin
                    locked_m = 0;
                    sbq.push_back('{kind: 1, per: per_m, cyc: cyc + LAT});
                end
                per_h[2] = per_h[1]; per_h[1] = per_h[0]; per_h[0] = per_m;
                lk_h[2] = lk_h[1]; lk_h[1] = lk_h[0]; lk_h[0] = locked_m;
            end
        end
    end

    // Monitor: compares pulses against the scoreboard and tracks held outputs.
    initial begin
        ev_t e;
        int  kind_act;
        forever begin
            @(negedge clk);
            if (rst_seen) begin
                chk("reset_outputs", {period, valid, timeout, glitch, locked}, 0);
            end else begin
                chk("period_held", period, per_h[2]);
                chk("locked", locked, lk_h[2]);
                if (valid | timeout | glitch) begin
                    chk("pulse_exclusive", $countones({valid, timeout, glitch}), 1);
                    kind_act = valid ? 0 : (timeout ? 1 : 2);
                    if (sbq.size() == 0) begin
                        chk("unexpected_pulse_kind", kind_act, -1);
                    end else begin
                        e = sbq.pop_front();
                        chk("event_kind", kind_act, e.kind);
                        chk("event_cycle", cyc, e.cyc);
                        chk("event_period", period, e.per);
                    end
                end
            end
        end
    end

    task automatic hold(input logic v, input int n);
        sig_in = v;
        repeat (n) @(negedge clk);
    endtask

    task automatic wave(input int per, input int hi, input int n);
        for (int i = 0; i < n; i++) begin
            hold(1'b1, hi);
            hold(1'b0, per - hi);
        end
    endtask

    initial begin
        int total, h;
        repeat (4) @(negedge clk);
        reset = 1'b0;
        hold(1'b0, 10);

        wave(100, 50, 5);                         // steady 100-cycle wave
        wave(37, 10, 5);                          // period change

        hold(1'b1, 1); hold(1'b0, 1);             // accepted edge, then glitch
        hold(1'b1, 2); hold(1'b0, 96);
        hold(1'b1, 3); hold(1'b0, 97);

        hold(1'b1, 3); hold(1'b0, 260);           // edges stop: timeout
        hold(1'b1, 3); hold(1'b0, 57);            // first edge again, no valid
        hold(1'b1, 3); hold(1'b0, 57);

        wave(int'(MAXC), 3, 2);                   // edge exactly at the timeout cycle
        hold(1'b1, 3); hold(1'b0, 260);

        hold(1'b1, 5); hold(1'b0, 45);            // reset mid-measurement
        reset = 1'b1;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        hold(1'b0, 47);
        wave(100, 5, 3);
        hold(1'b0, 260);

        for (int i = 0; i < 150; i++) begin
            case ($urandom_range(0, 3))
                0:       total = int'($urandom_range(2, 6));
                1:       total = int'($urandom_range(MAXC - 2, MAXC + 2));
                default: total = int'($urandom_range(4, 150));
            endcase
            h = 1 + int'($urandom_range(0, (total > 3) ? 2 : total - 2));
            hold(1'b1, h);
            hold(1'b0, total - h);
        end
        hold(1'b0, 300);

        chk("scoreboard_drained", sbq.size(), 0);
        $display("%0d/%0d checks passed", npass, ntotal);
        $finish;
    end

endmodule
